// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the front-end hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} hz_state_e;

  // Hazard causes, ordered so that a larger value wins when several are present.
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MC       = 2'd1,
    CAUSE_LOAD_USE = 2'd2,
    CAUSE_BRANCH   = 2'd3
  } hz_cause_e;

  typedef struct packed {
    logic ifid_we;
    logic pc_write;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam int REG_ZERO = 0;

  // Control words; CTRL_NOP_ALL loads NOPs into both IF/ID and ID/EX while holding PC.
  localparam ctrl_t CTRL_NORMAL  = '{ifid_we: 1'b1, pc_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam ctrl_t CTRL_NOP_ALL = '{ifid_we: 1'b0, pc_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_FLUSH   = '{ifid_we: 1'b1, pc_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_STALL   = '{ifid_we: 1'b0, pc_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_ISSUE   = '{ifid_we: 1'b0, pc_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/mc_stall_counter.sv
// Down-counter timing the multi-cycle freeze; loads MC_LATENCY-2 on issue.
module mc_stall_counter #(
  parameter int MC_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = $clog2(MC_LATENCY);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= W'(MC_LATENCY - 2);
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// IF/ID + PC sequencing for load-use, taken-branch and multi-cycle hazards.
// Define HAZ_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_mc_op,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  output logic                  IFIDControl,
  output logic                  pc_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  mc_busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  hz_state_e state, state_nxt;
  hz_cause_e cause;
  ctrl_t     ctrl;
  logic      load_use;
  logic      mc_load;
  logic      mc_zero;
  logic      branch_flush;

  assign load_use = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    cause = CAUSE_NONE;
    if (ex_branch_taken)   cause = CAUSE_BRANCH;
    else if (load_use)     cause = CAUSE_LOAD_USE;
    else if (id_mc_op)     cause = CAUSE_MC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ctrl         = CTRL_NORMAL;
    mc_load      = 1'b0;
    mc_busy      = 1'b0;
    branch_flush = 1'b0;
    if (reset) begin
      ctrl = CTRL_NOP_ALL;
    end else begin
      case (state)
        RUN: begin
          case (cause)
            CAUSE_BRANCH: begin
              ctrl         = CTRL_FLUSH;
              branch_flush = 1'b1;
            end
            CAUSE_LOAD_USE: ctrl = CTRL_STALL;
            CAUSE_MC: begin
              // Op goes to EX this cycle; the freeze continues in MC_WAIT.
              ctrl      = CTRL_ISSUE;
              mc_load   = 1'b1;
              state_nxt = MC_WAIT;
            end
            default: ctrl = CTRL_NORMAL;
          endcase
        end
        MC_WAIT: begin
          // EX only holds bubbles behind the op, so a branch here cannot be real.
          ctrl    = CTRL_STALL;
          mc_busy = 1'b1;
          if (mc_zero) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign IFIDControl = ctrl.ifid_we;
  assign pc_write    = ctrl.pc_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;

  mc_stall_counter #(.MC_LATENCY(MC_LATENCY)) u_mc_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (mc_load),
    .dec   (state == MC_WAIT),
    .zero  (mc_zero)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.ifid_we && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (branch_flush && flush_q != '1)  flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller against a cycle-level reference model.
module tb_pipeline_hazard_controller;
  localparam int RW  = 5;
  localparam int MCL = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, id_mc_op = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic          IFIDControl, pc_write, ifid_flush, idex_bubble, mc_busy;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_W(RW), .MC_LATENCY(MCL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .IFIDControl(IFIDControl), .pc_write(pc_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .mc_busy(mc_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Reference model: freeze cycles still owed after an issue, plus event tallies.
  int mc_left = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [4:0] mo;

  // Expected {IFIDControl, pc_write, ifid_flush, idex_bubble, mc_busy}.
  function automatic logic [4:0] model_out();
    logic lu;
    lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (reset)           return 5'b00110;
    if (mc_left > 0)     return 5'b00011;
    if (ex_branch_taken) return 5'b11110;
    if (lu)              return 5'b00010;
    if (id_mc_op)        return 5'b00000;
    return 5'b11000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_left <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      mo = model_out();
      if (!mo[4] && m_stall < SAT) m_stall <= m_stall + 1;
      if (mc_left == 0 && ex_branch_taken && m_flush < SAT) m_flush <= m_flush + 1;
      if (mc_left > 0)          mc_left <= mc_left - 1;
      else if (mo == 5'b00000)  mc_left <= MCL - 1;
    end
  end

  function automatic logic [4:0] dut_vec();
    return {IFIDControl, pc_write, ifid_flush, idex_bubble, mc_busy};
  endfunction

  function automatic int exp_stall();
`ifdef HAZ_PERF_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush();
`ifdef HAZ_PERF_CNT_EN
    return m_flush;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic urt,
                       input logic mc, input logic mr, input logic [RW-1:0] ert, input logic br);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_mc_op = mc;
    ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    drive(3, 3, 1, 1, 1, 3, 1);
    checks++;
    if (dut_vec() !== 5'b00110) $display("FAIL reset_forced: got %b want %b", dut_vec(), 5'b00110);
    else passes++;
    checks++;
    if (stall_cycles !== 0 || flush_count !== 0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
    else passes++;
    tick();
    checks++;
    if (dut_vec() !== model_out()) $display("FAIL reset_hold: got %b want %b", dut_vec(), model_out());
    else passes++;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== 5'b11000) $display("FAIL reset_release_run: got %b want %b", dut_vec(), 5'b11000);
    else passes++;
    tick();
  endtask

  task automatic test_load_use();
    drive(5, 0, 0, 0, 1, 5, 0);
    checks++;
    if (dut_vec() !== model_out()) $display("FAIL load_use_rs: got %b want %b", dut_vec(), model_out());
    else passes++;
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (dut_vec() !== model_out()) $display("FAIL load_use_r0: got %b want %b", dut_vec(), model_out());
    else passes++;
    tick();
  endtask

  task automatic test_uses_rt();
    drive(1, 7, 0, 0, 1, 7, 0);
    checks++;
    if (dut_vec() !== 5'b11000) $display("FAIL rt_unused: got %b want %b", dut_vec(), 5'b11000);
    else passes++;
    tick();
    drive(1, 7, 1, 0, 1, 7, 0);
    checks++;
    if (dut_vec() !== 5'b00010) $display("FAIL rt_used: got %b want %b", dut_vec(), 5'b00010);
    else passes++;
    tick();
  endtask

  task automatic test_mc();
    int frozen = 0;
    int busy = 0;
    drive(2, 3, 1, 1, 0, 0, 0);
    checks++;
    if (dut_vec() !== 5'b00000) $display("FAIL mc_issue: got %b want %b", dut_vec(), 5'b00000);
    else passes++;
    if (!IFIDControl) frozen++;
    tick();
    for (int i = 0; i < MCL + 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, (i == 1));
      checks++;
      if (dut_vec() !== model_out()) $display("FAIL mc_wait_c%0d: got %b want %b", i, dut_vec(), model_out());
      else passes++;
      if (!IFIDControl) frozen++;
      if (mc_busy) busy++;
      tick();
    end
    checks++;
    if (frozen !== MCL || busy !== MCL - 1)
      $display("FAIL mc_length: got frozen=%0d busy=%0d want %0d/%0d", frozen, busy, MCL, MCL - 1);
    else passes++;
  endtask

  task automatic test_branch_priority();
    pulse_reset();
    drive(5, 0, 0, 1, 1, 5, 1);
    checks++;
    if (dut_vec() !== 5'b11110) $display("FAIL branch_prio: got %b want %b", dut_vec(), 5'b11110);
    else passes++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== 5'b11000) $display("FAIL branch_no_mcwait: got %b want %b", dut_vec(), 5'b11000);
    else passes++;
    checks++;
`ifdef HAZ_PERF_CNT_EN
    if (flush_count !== 1 || stall_cycles !== 0)
      $display("FAIL branch_counts: got %0d/%0d want 1/0", flush_count, stall_cycles);
`else
    if (flush_count !== 0 || stall_cycles !== 0)
      $display("FAIL branch_counts: got %0d/%0d want 0/0", flush_count, stall_cycles);
`endif
    else passes++;
    tick();
  endtask

  task automatic test_counters();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin drive(4, 0, 0, 0, 1, 4, 0); tick(); end
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0, 0, 0, 1); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
`ifdef HAZ_PERF_CNT_EN
    if (stall_cycles !== 3 || flush_count !== 2)
      $display("FAIL perf_counts: got %0d/%0d want 3/2", stall_cycles, flush_count);
`else
    if (stall_cycles !== 0 || flush_count !== 0)
      $display("FAIL perf_counts: got %0d/%0d want 0/0", stall_cycles, flush_count);
`endif
    else passes++;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
      checks++;
      if (dut_vec() !== model_out()) $display("FAIL rand_ctrl_%0d: got %b want %b", n, dut_vec(), model_out());
      else passes++;
      checks++;
      if (stall_cycles !== CW'(exp_stall()) || flush_count !== CW'(exp_flush()))
        $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", n, stall_cycles, flush_count,
                 exp_stall(), exp_flush());
      else passes++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_uses_rt();
    test_mc();
    test_branch_priority();
    test_counters();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
